// File: rtl/softmax_pkg.sv
// Shared constants, state encoding and FP32 field helpers
// for the softmax sum controller.
package softmax_pkg;

  localparam int N_MAX  = 16;
  localparam int CNT_W  = 5;
  localparam int FP_W   = 32;

  localparam logic [FP_W-1:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [7:0]      FP_EXP_MAX = 8'hFF;

  localparam int SIGN_B = 31;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam int MAN_HI = 22;
  localparam int MAN_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [7:0] fp_exp(
    input logic [FP_W-1:0] v
  );
    return v[EXP_HI:EXP_LO];
  endfunction

  // Non-zero magnitude; the sign bit does not count.
  function automatic logic fp_nz(
    input logic [FP_W-1:0] v
  );
    return |{v[EXP_HI:EXP_LO], v[MAN_HI:MAN_LO]};
  endfunction

endpackage

// File: rtl/softmax_sum_if.sv
// Element stream, adder hookup and result handshake.
// slave = controller side, master = parent side.
interface softmax_sum_if;
  import softmax_pkg::*;

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [FP_W-1:0]  in_data;
  logic             in_ready;
  logic [FP_W-1:0]  add_a;
  logic [FP_W-1:0]  add_b;
  logic [FP_W-1:0]  add_s;
  logic [FP_W-1:0]  sum;
  logic             sum_valid;
  logic             sum_ready;
  logic             busy;
`ifdef SOFTMAX_SUM_FLAGS_EN
  logic             flag;
`endif

`ifdef SOFTMAX_SUM_FLAGS_EN
  modport slave (
    input  start, len, in_valid, in_data,
    input  add_s, sum_ready,
    output in_ready, add_a, add_b,
    output sum, sum_valid, busy, flag
  );
  modport master (
    output start, len, in_valid, in_data,
    output add_s, sum_ready,
    input  in_ready, add_a, add_b,
    input  sum, sum_valid, busy, flag
  );
`else
  modport slave (
    input  start, len, in_valid, in_data,
    input  add_s, sum_ready,
    output in_ready, add_a, add_b,
    output sum, sum_valid, busy
  );
  modport master (
    output start, len, in_valid, in_data,
    output add_s, sum_ready,
    input  in_ready, add_a, add_b,
    input  sum, sum_valid, busy
  );
`endif

endinterface

// File: rtl/softmax_sum_ctrl.sv
// Burst FP32 accumulator sequencing a parent-owned adder.
// Ports: clk, rst_n (async low), io (softmax_sum_if.slave);
// SOFTMAX_SUM_FLAGS_EN adds io.flag (exp overflow/underflow).
module softmax_sum_ctrl
  import softmax_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  softmax_sum_if.slave io
);

  state_e           state_q, state_d;
  logic [FP_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] len_c;
  logic             accept;

  assign len_c  = (io.len > CNT_W'(N_MAX))
                ? CNT_W'(N_MAX) : io.len;
  assign accept = (state_q == ACCUM) && io.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= FP_ZERO;
      rem_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    first_d = first_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (io.start) begin
          if (len_c != '0) begin
            rem_d   = len_c;
            first_d = 1'b1;
            state_d = ACCUM;
          end else begin
            acc_d   = FP_ZERO;
            state_d = DONE;
          end
        end
      end
      (state_q == ACCUM): begin
        if (accept) begin
          // First element bypasses the adder so +0
          // never reaches it.
          acc_d   = first_q ? io.in_data : io.add_s;
          first_d = 1'b0;
          rem_d   = rem_q - 1'b1;
          if (rem_q == CNT_W'(1))
            state_d = DONE;
        end
      end
      (state_q == DONE): begin
        if (io.sum_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.in_ready  = (state_q == ACCUM);
  assign io.sum_valid = (state_q == DONE);
  assign io.busy      = (state_q != IDLE);
  assign io.sum       = acc_q;
  assign io.add_a     = acc_q;
  assign io.add_b     = io.in_data;

`ifdef SOFTMAX_SUM_FLAGS_EN
  logic flag_q, flag_d;
  logic s_bad;

  // add_s only matters when it is registered.
  assign s_bad =
    (fp_exp(io.add_s) == FP_EXP_MAX) ||
    ((fp_exp(io.add_s) == 8'h00) &&
     fp_nz(acc_q) && fp_nz(io.in_data));

  always_comb begin
    flag_d = flag_q;
    if ((state_q == IDLE) && io.start &&
        (len_c != '0))
      flag_d = 1'b0;
    if (accept) begin
      if (fp_exp(io.in_data) == FP_EXP_MAX)
        flag_d = 1'b1;
      if (!first_q && s_bad)
        flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_q <= 1'b0;
    else        flag_q <= flag_d;
  end

  assign io.flag = flag_q;
`endif

endmodule

// File: tb/tb_softmax_sum_ctrl.sv
// Randomised + directed bench for softmax_sum_ctrl with a
// truncating FP32 adder model standing in for the parent.
module tb_softmax_sum_ctrl;
  import softmax_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  softmax_sum_if bus();

  softmax_sum_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  int nchk = 0;
  int nfail = 0;

  bit force_x = 1'b0;
  bit chk_en = 1'b0;
  bit e_busy, e_ir, e_sv;
  logic [31:0] acc_m;
  bit flag_m;
  logic [31:0] elq[$];

  // Truncating adder for positive normals, hidden bit always set.
  function automatic logic [31:0] fadd(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] x, y;
    logic [23:0] mx, my;
    logic [24:0] s;
    int d;
    if (a[30:23] >= b[30:23]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = int'(x[30:23]) - int'(y[30:23]);
    mx = {1'b1, x[22:0]};
    my = (d > 23) ? 24'd0 : ({1'b1, y[22:0]} >> d);
    s  = {1'b0, mx} + {1'b0, my};
    if (s[24])
      return {1'b0, 8'(x[30:23] + 8'd1), s[23:1]};
    return {1'b0, x[30:23], s[22:0]};
  endfunction

  always_comb
    bus.add_s = force_x ? 32'hDEADBEEF
                        : fadd(bus.add_a, bus.add_b);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp_v);
    nchk++;
    if (act !== exp_v) begin
      nfail++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp_v, $time);
    end
  endtask

  task automatic expect_st(input bit b, input bit ir,
                           input bit sv);
    e_busy = b; e_ir = ir; e_sv = sv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("in_ready", 32'(bus.in_ready), 32'(e_ir));
      chk("sum_valid", 32'(bus.sum_valid), 32'(e_sv));
      chk("add_a", bus.add_a, acc_m);
      chk("add_b", bus.add_b, bus.in_data);
      if (e_sv) chk("sum", bus.sum, acc_m);
`ifdef SOFTMAX_SUM_FLAGS_EN
      chk("flag", 32'(bus.flag), 32'(flag_m));
`endif
    end
  end

  function automatic logic [31:0] rnd_elem();
    return {1'b0, 8'($urandom_range(120, 134)),
            23'($urandom)};
  endfunction

  task automatic burst(input int len, input int gap,
                       input int hold, input int abort_at,
                       output logic [31:0] s_out,
                       output int lat);
    int n;
    int cyc;
    logic [31:0] r;
    n = (len > N_MAX) ? N_MAX : len;
    if (elq.size() == 0)
      for (int i = 0; i < n; i++) elq.push_back(rnd_elem());
    s_out = 'x;
    lat = -1;
    bus.start = 1'b1;
    bus.len = CNT_W'(len);
    expect_st(0, 0, 0);
    cyc = 1;
    step(); cyc++;
    bus.start = 1'b0;
    if (n == 0) begin
      acc_m = FP_ZERO;
      expect_st(1, 0, 1);
    end else begin
      expect_st(1, 1, 0);
      flag_m = 1'b0;
      for (int i = 0; i < n; i++) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          bus.in_data = $urandom;
          if ($urandom_range(1) == 1) begin
            bus.start = 1'b1;
            bus.len = CNT_W'($urandom_range(0, 16));
          end
          step(); cyc++;
          bus.start = 1'b0;
        end
        if (i == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_busy", 32'(bus.busy), 0);
          chk("rst_in_ready", 32'(bus.in_ready), 0);
          chk("rst_sum_valid", 32'(bus.sum_valid), 0);
          chk("rst_sum", bus.sum, 32'h0);
          chk("rst_add_a", bus.add_a, 32'h0);
`ifdef SOFTMAX_SUM_FLAGS_EN
          chk("rst_flag", 32'(bus.flag), 0);
`endif
          acc_m = FP_ZERO;
          flag_m = 1'b0;
          expect_st(0, 0, 0);
          step();
          rst_n = 1'b1;
          elq.delete();
          return;
        end
        bus.in_valid = 1'b1;
        bus.in_data = elq[i];
        step(); cyc++;
        if (elq[i][30:23] == 8'hFF) flag_m = 1'b1;
        if (i > 0) begin
          r = fadd(acc_m, elq[i]);
          if (r[30:23] == 8'hFF ||
              (r[30:23] == 8'h00 && acc_m[30:0] != 0 &&
               elq[i][30:0] != 0))
            flag_m = 1'b1;
          acc_m = r;
        end else begin
          acc_m = elq[i];
        end
        bus.in_valid = 1'b0;
        bus.in_data = $urandom;
        if (i == n - 1) expect_st(1, 0, 1);
      end
    end
    lat = cyc;
    s_out = bus.sum;
    for (int h = 0; h < hold; h++) begin
      bus.sum_ready = 1'b0;
      if ($urandom_range(1) == 1) begin
        bus.start = 1'b1;
        bus.len = CNT_W'($urandom_range(0, 16));
      end
      step();
      bus.start = 1'b0;
    end
    bus.sum_ready = 1'b1;
    step();
    bus.sum_ready = 1'b0;
    expect_st(0, 0, 0);
    elq.delete();
  endtask

  logic [31:0] s;
  int lat;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.sum_ready = 1'b0;
    acc_m = FP_ZERO;
    flag_m = 1'b0;
    expect_st(0, 0, 0);
    step();
    chk("init_busy", 32'(bus.busy), 0);
    chk("init_in_ready", 32'(bus.in_ready), 0);
    chk("init_sum_valid", 32'(bus.sum_valid), 0);
    chk("init_sum", bus.sum, 32'h0);
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    elq = '{32'h3F800000, 32'h40000000, 32'h3F000000};
    burst(3, 0, 0, -1, s, lat);
    chk("t1_sum", s, 32'h40600000);
    chk("t1_latency", 32'(lat), 32'd5);

    force_x = 1'b1;
    elq = '{32'h3F800000};
    burst(1, 0, 2, -1, s, lat);
    chk("t2_bypass", s, 32'h3F800000);
    force_x = 1'b0;

    burst(0, 0, 1, -1, s, lat);
    chk("t3_zero", s, 32'h0);
    chk("t3_latency", 32'(lat), 32'd2);

    elq = '{32'h3F800000, 32'h40000000};
    burst(2, 3, 5, -1, s, lat);
    chk("t4_sum", s, 32'h40400000);

    burst(4, 0, 0, 2, s, lat);
    elq = '{32'h40000000};
    burst(1, 0, 0, -1, s, lat);
    chk("t5_after_rst", s, 32'h40000000);

    burst(20, 0, 0, -1, s, lat);
    chk("clamp_latency", 32'(lat), 32'd18);

    repeat (25)
      burst($urandom_range(0, N_MAX), $urandom_range(0, 2),
            $urandom_range(0, 3), -1, s, lat);

`ifdef SOFTMAX_SUM_FLAGS_EN
    elq = '{32'h7F800000, 32'h3F800000};
    burst(2, 0, 0, -1, s, lat);
    chk("t6_flag_set", 32'(bus.flag), 1);
    elq = '{32'h3F800000, 32'h3F800000};
    burst(2, 0, 0, -1, s, lat);
    chk("t6_flag_clr", 32'(bus.flag), 0);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
